// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC source encodings, flow-control FSM states and
// the control bundles driven to the PC, IF/ID and ID/EX registers.
package cpu_pkg;

  localparam int unsigned RegAddrW = 5;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JMP    = 2'b10;
  localparam logic [1:0] NPC_REG    = 2'b11;

  typedef enum logic [1:0] {
    StRun,
    StLuStall,
    StRedirect
  } flow_state_e;

  typedef struct packed {
    logic npc_stall;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } flow_ctrl_t;

  localparam flow_ctrl_t CtrlRun = '{
    npc_stall: 1'b0, pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0
  };

  // Reset state: nothing written, IF/ID and ID/EX forced to NOPs.
  localparam flow_ctrl_t CtrlReset = '{
    npc_stall: 1'b0, pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a load in ID/EX writing a register read by the
// instruction in IF/ID. Writes to $zero never create a dependency.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                mem_read_i,
  input  logic [RegAddrW-1:0] ex_rt_i,
  input  logic [RegAddrW-1:0] id_rs_i,
  input  logic [RegAddrW-1:0] id_rt_i,
  output logic                hazard_o
);

  assign hazard_o = mem_read_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pc_flow_ctrl.sv
// Pipeline flow controller: arbitrates memory wait, ID/EX redirects and load-use
// stalls, drives next-PC select and pipeline register enables, counts events.
module pc_flow_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_is_branch,
  input  logic             id_ex_is_jump,
  input  logic             id_ex_is_jr,
  input  logic             branch_test,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             mem_busy,
  output logic [1:0]       npc_from,
  output logic             npc_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam bit         LongFlush = (FLUSH_CYCLES > 1);
  localparam logic [2:0] FcntInit  = LongFlush ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  flow_state_e      state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             load_use, redirect;
  flow_ctrl_t       ctrl;

  hazard_detect u_hazard_detect (
    .mem_read_i (id_ex_mem_read),
    .ex_rt_i    (id_ex_rt),
    .id_rs_i    (if_id_rs),
    .id_rt_i    (if_id_rt),
    .hazard_o   (load_use)
  );

  assign redirect = (id_ex_is_branch && branch_test) || id_ex_is_jump || id_ex_is_jr;

  // Branches select BRANCH even when not taken; the next-PC unit applies the test.
  always_comb begin
    npc_from = NPC_PC4;
    if (rst)                  npc_from = NPC_PC4;
    else if (id_ex_is_jr)     npc_from = NPC_REG;
    else if (id_ex_is_jump)   npc_from = NPC_JMP;
    else if (id_ex_is_branch) npc_from = NPC_BRANCH;
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    ctrl      = CtrlRun;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      ctrl = CtrlReset;
    end else if (mem_busy) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      stall_inc        = 1'b1;
    end else begin
      unique case (state_q)
        StRun, StLuStall: begin
          if (redirect) begin
            // Redirect beats load-use: the hazarding IF/ID instruction is wrong-path.
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            flush_inc         = 1'b1;
            state_d           = LongFlush ? StRedirect : StRun;
            fcnt_d            = FcntInit;
          end else if (load_use && (state_q == StRun)) begin
            ctrl.npc_stall    = 1'b1;
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            stall_inc         = 1'b1;
            state_d           = StLuStall;
          end else begin
            state_d = StRun;
          end
        end
        StRedirect: begin
          ctrl.if_id_flush = 1'b1;
          if (fcnt_q == 3'd0) state_d = StRun;
          else                fcnt_d  = fcnt_q - 3'd1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      fcnt_q  <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign npc_stall    = ctrl.npc_stall;
  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the flow rules.
module tb_pc_flow_ctrl;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 8;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_ex_is_branch, id_ex_is_jump, id_ex_is_jr, branch_test;
  logic             id_ex_mem_read, mem_busy;
  logic [4:0]       id_ex_rt, if_id_rs, if_id_rt;
  logic [1:0]       npc_from;
  logic             npc_stall, pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [6:0]       ctl;

  int n_run  = 0;
  int n_fail = 0;

  // Model state: remaining post-decision flush cycles, previous cycle was a
  // load-use stall, and event counts.
  int         m_left, m_stall, m_flush;
  bit         m_shadow;
  int         n_left, n_stall, n_flush;
  bit         n_shadow;
  logic [6:0] e_ctl;

  pc_flow_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ex_is_branch (id_ex_is_branch),
    .id_ex_is_jump   (id_ex_is_jump),
    .id_ex_is_jr     (id_ex_is_jr),
    .branch_test     (branch_test),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rt        (id_ex_rt),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .mem_busy        (mem_busy),
    .npc_from        (npc_from),
    .npc_stall       (npc_stall),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  // {npc_from, npc_stall, pc_write, if_id_write, if_id_flush, id_ex_bubble}
  assign ctl = {npc_from, npc_stall, pc_write, if_id_write, if_id_flush, id_ex_bubble};

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_ex_is_branch = 1'b0;
    id_ex_is_jump   = 1'b0;
    id_ex_is_jr     = 1'b0;
    branch_test     = 1'b0;
    id_ex_mem_read  = 1'b0;
    mem_busy        = 1'b0;
    id_ex_rt        = 5'd0;
    if_id_rs        = 5'd0;
    if_id_rt        = 5'd0;
  endtask

  task automatic model_eval();
    bit redir, lu;
    logic [1:0] from;
    redir = (id_ex_is_branch && branch_test) || id_ex_is_jump || id_ex_is_jr;
    lu    = id_ex_mem_read && (id_ex_rt != 0) && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    from  = id_ex_is_jr ? 2'b11 : id_ex_is_jump ? 2'b10 : id_ex_is_branch ? 2'b01 : 2'b00;
    n_left   = m_left;
    n_shadow = m_shadow;
    n_stall  = m_stall;
    n_flush  = m_flush;
    e_ctl    = {from, 5'b01100};
    if (rst) begin
      e_ctl    = 7'b00_0_0_0_1_1;
      n_left   = 0;
      n_shadow = 0;
      n_stall  = 0;
      n_flush  = 0;
    end else if (mem_busy) begin
      e_ctl   = {from, 5'b00000};
      n_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
    end else if (m_left > 0) begin
      e_ctl[1] = 1'b1;
      n_left   = m_left - 1;
      n_shadow = 0;
    end else if (redir) begin
      e_ctl[1:0] = 2'b11;
      n_flush    = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      n_left     = FLUSH_CYCLES - 1;
      n_shadow   = 0;
    end else if (lu && !m_shadow) begin
      e_ctl[4:0] = 5'b10001;
      n_stall    = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      n_shadow   = 1;
    end else begin
      n_shadow = 0;
    end
  endtask

  // One clock: evaluate the model on the pre-edge inputs, then commit after the edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    m_left   = n_left;
    m_shadow = n_shadow;
    m_stall  = n_stall;
    m_flush  = n_flush;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    id_ex_is_jr = 1'b1;
    tick();
    tick();
    #1;
    n_run++;
    if (ctl !== 7'b00_0_0_0_1_1) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", ctl, 7'b00_0_0_0_1_1);
    end
    n_run++;
    if (stall_cycles !== 0 || flush_events !== 0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_0_0) begin
      n_fail++;
      $display("FAIL idle_ctl: got %b want %b", ctl, 7'b00_0_1_1_0_0);
    end
    tick();
  endtask

  task automatic test_branch();
    id_ex_is_branch = 1'b1;
    branch_test     = 1'b1;
    #1;
    n_run++;
    if (ctl !== 7'b01_0_1_1_1_1) begin
      n_fail++;
      $display("FAIL taken_decision: got %b want %b", ctl, 7'b01_0_1_1_1_1);
    end
    tick();
    clear_inputs();
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_1_0) begin
      n_fail++;
      $display("FAIL taken_second_flush: got %b want %b", ctl, 7'b00_0_1_1_1_0);
    end
    tick();
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_0_0) begin
      n_fail++;
      $display("FAIL taken_end: got %b want %b", ctl, 7'b00_0_1_1_0_0);
    end
    n_run++;
    if (flush_events !== 8'd1) begin
      n_fail++;
      $display("FAIL taken_count: got %0d want 1", flush_events);
    end
    id_ex_is_branch = 1'b1;
    branch_test     = 1'b0;
    #1;
    n_run++;
    if (ctl !== 7'b01_0_1_1_0_0) begin
      n_fail++;
      $display("FAIL not_taken: got %b want %b", ctl, 7'b01_0_1_1_0_0);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_load_use();
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd8;
    if_id_rs       = 5'd8;
    #1;
    n_run++;
    if (ctl !== 7'b00_1_0_0_0_1) begin
      n_fail++;
      $display("FAIL lu_stall: got %b want %b", ctl, 7'b00_1_0_0_0_1);
    end
    tick();
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_0_0) begin
      n_fail++;
      $display("FAIL lu_release: got %b want %b", ctl, 7'b00_0_1_1_0_0);
    end
    tick();
    clear_inputs();
    #1;
    n_run++;
    if (stall_cycles !== 8'd1) begin
      n_fail++;
      $display("FAIL lu_count: got %0d want 1", stall_cycles);
    end
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd0;
    if_id_rs       = 5'd0;
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_0_0) begin
      n_fail++;
      $display("FAIL lu_zero_reg: got %b want %b", ctl, 7'b00_0_1_1_0_0);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_jr_load_use();
    id_ex_is_jr    = 1'b1;
    id_ex_mem_read = 1'b1;
    id_ex_rt       = 5'd9;
    if_id_rt       = 5'd9;
    #1;
    n_run++;
    if (ctl !== 7'b11_0_1_1_1_1) begin
      n_fail++;
      $display("FAIL jr_beats_lu: got %b want %b", ctl, 7'b11_0_1_1_1_1);
    end
    tick();
    clear_inputs();
    #1;
    n_run++;
    if (stall_cycles !== 8'd1 || flush_events !== 8'd2) begin
      n_fail++;
      $display("FAIL jr_counts: got %0d/%0d want 1/2", stall_cycles, flush_events);
    end
    tick();
  endtask

  task automatic test_mem_busy_redirect();
    id_ex_is_jump = 1'b1;
    #1;
    n_run++;
    if (ctl !== 7'b10_0_1_1_1_1) begin
      n_fail++;
      $display("FAIL jump_decision: got %b want %b", ctl, 7'b10_0_1_1_1_1);
    end
    tick();
    clear_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (ctl !== 7'b00_0_0_0_0_0) begin
        n_fail++;
        $display("FAIL busy_freeze[%0d]: got %b want %b", i, ctl, 7'b00_0_0_0_0_0);
      end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_1_0) begin
      n_fail++;
      $display("FAIL busy_resume_flush: got %b want %b", ctl, 7'b00_0_1_1_1_0);
    end
    tick();
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_0_0 || stall_cycles !== 8'd4 || flush_events !== 8'd3) begin
      n_fail++;
      $display("FAIL busy_end: got %b %0d/%0d want %b 4/3", ctl, stall_cycles, flush_events,
               7'b00_0_1_1_0_0);
    end
  endtask

  task automatic test_reset_mid_and_saturate();
    id_ex_is_jump = 1'b1;
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    n_run++;
    if (ctl !== 7'b00_0_0_0_1_1) begin
      n_fail++;
      $display("FAIL mid_reset_ctl: got %b want %b", ctl, 7'b00_0_0_0_1_1);
    end
    tick();
    rst = 1'b0;
    #1;
    n_run++;
    if (ctl !== 7'b00_0_1_1_0_0 || stall_cycles !== 0 || flush_events !== 0) begin
      n_fail++;
      $display("FAIL post_reset: got %b %0d/%0d want %b 0/0", ctl, stall_cycles, flush_events,
               7'b00_0_1_1_0_0);
    end
    mem_busy = 1'b1;
    for (int i = 0; i < CNT_MAX + 4; i++) tick();
    n_run++;
    if (stall_cycles !== 8'hFF) begin
      n_fail++;
      $display("FAIL stall_saturate: got %0d want 255", stall_cycles);
    end
    tick();
    n_run++;
    if (stall_cycles !== 8'hFF) begin
      n_fail++;
      $display("FAIL stall_hold_max: got %0d want 255", stall_cycles);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(99) == 0);
      id_ex_is_branch = ($urandom_range(5) == 0);
      id_ex_is_jump   = ($urandom_range(15) == 0);
      id_ex_is_jr     = ($urandom_range(15) == 0);
      branch_test     = 1'($urandom_range(1));
      id_ex_mem_read  = ($urandom_range(2) == 0);
      id_ex_rt        = 5'($urandom_range(3));
      if_id_rs        = 5'($urandom_range(3));
      if_id_rt        = 5'($urandom_range(3));
      mem_busy        = ($urandom_range(6) == 0);
      #1;
      model_eval();
      n_run++;
      if (ctl !== e_ctl || stall_cycles !== CNT_W'(m_stall) || flush_events !== CNT_W'(m_flush))
      begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got %b %0d/%0d want %b %0d/%0d", i, ctl, stall_cycles,
                   flush_events, e_ctl, m_stall, m_flush);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    m_left   = 0;
    m_shadow = 0;
    m_stall  = 0;
    m_flush  = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_branch();
    test_load_use();
    test_jr_load_use();
    test_mem_busy_redirect();
    test_reset_mid_and_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
